// File: rtl/macro_sched.sv
// Job scheduler between two requesters and a bit-serial sequencer.
// Arbitrates requests round-robin, issues a one-cycle start pulse, follows the
// sequencer accumulator flag low then high, and holds a completion response
// until the consumer acknowledges it.
// Optional watchdog: define MACRO_SCHED_WATCHDOG_EN to abort a job whose
// sequencer flag does not reach the awaited level within TIMEOUT_CYC cycles
// of a wait phase; the job then completes with done_err set.
module macro_sched #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic [1:0] req_width,
  input  logic [3:0] req_bank,
  output logic [1:0] gnt,
  output logic       seq_start,
  output logic       seq_inwidth,
  output logic [1:0] seq_bank,
  input  logic       seq_st,
  output logic       done_valid,
  output logic       done_id,
  output logic       done_err,
  input  logic       done_ready,
  output logic       busy,
  output logic [7:0] job_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StWaitLo = 3'd2,
    StWaitHi = 3'd3,
    StResp   = 3'd4
  } state_e;

  state_e state_q;
  logic   last_q;  // requester granted most recently
  logic   id_q;    // requester owning the job in flight
  logic   win;

`ifdef MACRO_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);
  logic [WdW-1:0] wd_q;
`else
  assign done_err = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, on a tie the one not granted last wins
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      gnt         <= 2'b00;
      seq_start   <= 1'b0;
      seq_inwidth <= 1'b0;
      seq_bank    <= 2'b00;
      done_valid  <= 1'b0;
      done_id     <= 1'b0;
      busy        <= 1'b0;
      job_cnt     <= 8'd0;
`ifdef MACRO_SCHED_WATCHDOG_EN
      done_err    <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      // grant and start are single-cycle pulses
      gnt       <= 2'b00;
      seq_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StIssue;
            id_q        <= win;
            last_q      <= win;
            seq_inwidth <= req_width[win];
            seq_bank    <= win ? req_bank[3:2] : req_bank[1:0];
            gnt         <= win ? 2'b10 : 2'b01;
            seq_start   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWaitLo;
`ifdef MACRO_SCHED_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        StWaitLo: begin
          if (!seq_st) begin
            state_q <= StWaitHi;
`ifdef MACRO_SCHED_WATCHDOG_EN
            wd_q    <= '0;
          end else if (wd_q == WdLast) begin
            state_q    <= StResp;
            done_valid <= 1'b1;
            done_id    <= id_q;
            done_err   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        StWaitHi: begin
          if (seq_st) begin
            state_q    <= StResp;
            done_valid <= 1'b1;
            done_id    <= id_q;
`ifdef MACRO_SCHED_WATCHDOG_EN
            done_err   <= 1'b0;
          end else if (wd_q == WdLast) begin
            state_q    <= StResp;
            done_valid <= 1'b1;
            done_id    <= id_q;
            done_err   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        StResp: begin
          if (done_ready) begin
            state_q    <= StIdle;
            done_valid <= 1'b0;
            busy       <= 1'b0;
            job_cnt    <= job_cnt + 8'd1;
          end
        end
        default: begin
          // unreachable encoding: recover to the reset condition
          state_q     <= StIdle;
          last_q      <= 1'b1;
          id_q        <= 1'b0;
          gnt         <= 2'b00;
          seq_start   <= 1'b0;
          seq_inwidth <= 1'b0;
          seq_bank    <= 2'b00;
          done_valid  <= 1'b0;
          done_id     <= 1'b0;
          busy        <= 1'b0;
          job_cnt     <= 8'd0;
`ifdef MACRO_SCHED_WATCHDOG_EN
          done_err    <= 1'b0;
          wd_q        <= '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_macro_sched.sv
// Self-checking bench for macro_sched: a job-level model predicts every
// output each cycle, and directed scenarios pin literal expectations.
module tb_macro_sched;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] req_width = 2'b10;
  logic [3:0] req_bank = 4'b1110;  // requester 0: bank 2, requester 1: bank 3
  logic [1:0] gnt;
  logic       seq_start;
  logic       seq_inwidth;
  logic [1:0] seq_bank;
  logic       seq_st = 1'b1;
  logic       done_valid;
  logic       done_id;
  logic       done_err;
  logic       done_ready = 1'b0;
  logic       busy;
  logic [7:0] job_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  macro_sched #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .req_width  (req_width),
    .req_bank   (req_bank),
    .gnt        (gnt),
    .seq_start  (seq_start),
    .seq_inwidth(seq_inwidth),
    .seq_bank   (seq_bank),
    .seq_st     (seq_st),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_err   (done_err),
    .done_ready (done_ready),
    .busy       (busy),
    .job_cnt    (job_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job-level model. m_phase: 0 idle, 1 issuing, 2 awaiting flag low,
  // 3 awaiting flag high, 4 response pending.
  int m_phase = 0;
  int m_cnt = 0;
  int m_wd = 0;
  bit m_last = 1'b1;
  bit m_id = 1'b0;
  bit m_err = 1'b0;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    m_ok = 1'b1;
    if (!rstn) begin
      m_phase = 0;
      m_cnt = 0;
      m_wd = 0;
      m_last = 1'b1;
      m_id = 1'b0;
      m_err = 1'b0;
    end else if (m_phase == 0) begin
      if (req != 2'b00) begin
        m_id = (req == 2'b11) ? !m_last : req[1];
        m_last = m_id;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_wd = 0;
    end else if (m_phase == 2 || m_phase == 3) begin
      if ((m_phase == 2 && !seq_st) || (m_phase == 3 && seq_st)) begin
        if (m_phase == 3) m_err = 1'b0;
        m_phase = m_phase + 1;
        m_wd = 0;
      end else begin
        m_wd = m_wd + 1;
`ifdef MACRO_SCHED_WATCHDOG_EN
        if (m_wd == TO) begin
          m_phase = 4;
          m_err = 1'b1;
        end
`endif
      end
    end else if (m_phase == 4) begin
      if (done_ready) begin
        m_phase = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("gnt", gnt, (m_phase == 1) ? (1 << m_id) : 0);
      chk("seq_start", seq_start, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("done_valid", done_valid, m_phase == 4);
      chk("job_cnt", job_cnt, m_cnt);
      if (m_phase != 0) begin
        chk("seq_inwidth", seq_inwidth, req_width[m_id]);
        chk("seq_bank", seq_bank, m_id ? req_bank[3:2] : req_bank[1:0]);
      end
      if (m_phase == 4) begin
        chk("done_id", done_id, m_id);
        chk("done_err", done_err, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    int n = 0;
    while (gnt == 2'b00 && n < 20) begin
      step();
      n++;
    end
    chk("gnt_arrives", gnt != 2'b00, 1);
    g = gnt;
  endtask

  task automatic wait_dv();
    int n = 0;
    while (!done_valid && n < 40) begin
      step();
      n++;
    end
    chk("done_valid_arrives", done_valid, 1);
  endtask

  // One full job: request, sequencer low then high, acknowledge
  task automatic do_job(input logic [1:0] r, input bit keep_req, input bit keep_ready,
                        output logic [1:0] g, output logic id);
    req = r;
    wait_gnt(g);
    if (!keep_req) req = 2'b00;
    seq_st = 1'b0;
    step();
    step();
    seq_st = 1'b1;
    wait_dv();
    id = done_id;
    done_ready = 1'b1;
    step();
    if (!keep_ready) done_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  logic [1:0] g;
  logic       id;
  logic [1:0] g_log [3];
  logic       id_log[3];

  initial begin
    // reset state
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_cnt", job_cnt, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_seq_bank", seq_bank, 0);
    rstn = 1'b1;

    // single job, requester 0, 12-bit, bank 2
    req = 2'b01;
    step();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_seq_start", seq_start, 1);
    chk("t1_seq_bank", seq_bank, 2);
    chk("t1_seq_inwidth", seq_inwidth, 0);
    req = 2'b00;
    seq_st = 1'b0;
    step();
    chk("t1_gnt_pulse", gnt, 0);
    chk("t1_start_pulse", seq_start, 0);
    step();
    step();
    seq_st = 1'b1;
    wait_dv();
    chk("t1_done_id", done_id, 0);
    chk("t1_done_err", done_err, 0);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("t1_job_cnt", job_cnt, 1);
    chk("t1_idle", busy, 0);

    // both requesting, ready held high: grants alternate starting at 0
    do_reset();
    done_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_job(2'b11, 1'b1, 1'b1, g, id);
      g_log[i] = g;
      id_log[i] = id;
    end
    req = 2'b00;
    done_ready = 1'b0;
    chk("rr_gnt0", g_log[0], 2'b01);
    chk("rr_gnt1", g_log[1], 2'b10);
    chk("rr_gnt2", g_log[2], 2'b01);
    chk("rr_id0", id_log[0], 0);
    chk("rr_id1", id_log[1], 1);
    chk("rr_id2", id_log[2], 0);
    step();
    chk("rr_job_cnt", job_cnt, 3);

    // response held 10 cycles while requester 1 waits
    req = 2'b01;
    wait_gnt(g);
    req = 2'b10;
    seq_st = 1'b0;
    step();
    step();
    seq_st = 1'b1;
    wait_dv();
    for (int i = 0; i < 10; i++) begin
      chk("hold_dv", done_valid, 1);
      chk("hold_id", done_id, 0);
      chk("hold_bank", seq_bank, 2);
      chk("hold_gnt", gnt, 0);
      chk("hold_busy", busy, 1);
      step();
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("hs_dv", done_valid, 0);
    chk("hs_busy", busy, 0);
    chk("hs_gnt", gnt, 0);
    chk("hs_job_cnt", job_cnt, 4);
    step();
    chk("next_gnt", gnt, 2'b10);
    chk("next_inwidth", seq_inwidth, 1);
    chk("next_bank", seq_bank, 3);
    req = 2'b00;
    seq_st = 1'b0;
    step();
    step();
    seq_st = 1'b1;
    wait_dv();
    chk("next_done_id", done_id, 1);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;

    // a request raised and dropped while busy is never issued
    req = 2'b01;
    wait_gnt(g);
    req = 2'b10;
    step();
    req = 2'b00;
    seq_st = 1'b0;
    step();
    seq_st = 1'b1;
    wait_dv();
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drop_gnt", gnt, 0);
      chk("drop_busy", busy, 0);
      step();
    end
    chk("drop_job_cnt", job_cnt, 6);

    // 256 jobs wrap the counter
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      do_job(2'b01, 1'b0, 1'b0, g, id);
      if (i == 255) chk("cnt_255", job_cnt, 255);
    end
    chk("cnt_wrap", job_cnt, 0);

    // sequencer flag stuck high
    req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    seq_st = 1'b1;
    step();
`ifdef MACRO_SCHED_WATCHDOG_EN
    begin
      int n = 0;
      while (!done_valid && n < 30) begin
        step();
        n++;
      end
      chk("wd_latency", n, TO);
      chk("wd_err", done_err, 1);
      chk("wd_id", done_id, 0);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
    end
`else
    for (int i = 0; i < 30; i++) begin
      chk("stuck_busy", busy, 1);
      chk("stuck_dv", done_valid, 0);
      step();
    end
`endif
    do_reset();

    // reset while awaiting flag high, requester 1 pending
    req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    seq_st = 1'b0;
    step();
    step();
    req = 2'b10;
    rstn = 1'b0;
    step();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_start", seq_start, 0);
    chk("mid_rst_inwidth", seq_inwidth, 0);
    chk("mid_rst_bank", seq_bank, 0);
    chk("mid_rst_dv", done_valid, 0);
    chk("mid_rst_id", done_id, 0);
    chk("mid_rst_err", done_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", job_cnt, 0);
    rstn = 1'b1;
    seq_st = 1'b1;
    step();
    chk("post_rst_gnt", gnt, 2'b10);
    req = 2'b00;
    seq_st = 1'b0;
    step();
    step();
    seq_st = 1'b1;
    wait_dv();
    chk("post_rst_id", done_id, 1);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("post_rst_cnt", job_cnt, 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/macro_sched.md
MACRO_SCHED -- requirements
Module: macro_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, meaning the watchdog limit in cycles per wait phase.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rstn  in  1  reset, synchronous and active-low.
REQ-004 req  in  2  per-requester job request; bit i belongs to requester i.
REQ-005 req_width  in  2  per-requester precision; bit i: 0=12-bit, 1=24-bit.
REQ-006 req_bank  in  4  per-requester bank select; requester i uses bits [2i+1:2i].
REQ-007 gnt  out  2  one-hot grant, a one-cycle pulse.
REQ-008 seq_start  out  1  one-cycle start pulse to the bit-serial sequencer.
REQ-009 seq_inwidth  out  1  precision of the job in flight.
REQ-010 seq_bank  out  2  bank of the job in flight.
REQ-011 seq_st  in  1  sequencer accumulator flag; 1=stopped, 0=accumulating.
REQ-012 done_valid  out  1  job-complete indication.
REQ-013 done_id  out  1  requester index of the completed job.
REQ-014 done_err  out  1  completed job aborted by watchdog.
REQ-015 done_ready  in  1  consumer acknowledge.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 job_cnt  out  8  count of completed handshakes.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP; all outputs registered.
REQ-019 IDLE: if any req bit is sampled high -> ISSUE next cycle, latching the winner's id, width and bank; otherwise stay in IDLE.
REQ-020 Arbitration is round-robin: when both requesters are high, the requester not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-021 ISSUE lasts exactly one cycle, with gnt[id]=1 and seq_start=1 in that cycle only, then -> WAIT_LO.
REQ-022 Latency from req sampled in IDLE to the gnt/seq_start pulse is 1 cycle.
REQ-023 seq_inwidth and seq_bank hold the latched values from ISSUE through RESP and are not changed by req inputs.
REQ-024 WAIT_LO: seq_st==0 -> WAIT_HI.
REQ-025 WAIT_HI: seq_st==1 -> RESP, setting done_valid=1, done_id=id, done_err=0.
REQ-026 RESP: done_valid and done_id stay stable until done_valid&done_ready.
REQ-027 On the RESP handshake: -> IDLE, done_valid=0, job_cnt+1, wrapping from 255 to 0.
REQ-028 A new grant is possible no earlier than the cycle after the IDLE cycle that follows a handshake, so there is no back-to-back ISSUE.
REQ-029 done_ready while not in RESP is ignored.
REQ-030 A requester dropping req before gnt is legal; no job is issued for a request not sampled in IDLE.
REQ-031 req held high after gnt is treated as a new job at the next IDLE.
REQ-032 An illegal state encoding -> IDLE with all outputs at their reset values.

Reset
REQ-033 rstn low at a clock edge -> state IDLE, gnt=0, seq_start=0, seq_inwidth=0, seq_bank=0, done_valid=0, done_id=0, done_err=0, busy=0, job_cnt=0, round-robin pointer=1, watchdog counter=0.
REQ-034 Reset mid-job abandons the job with no done_valid; the sequencer is not reset by this block.

Configuration
REQ-035 Macro MACRO_SCHED_WATCHDOG_EN: when defined, a counter clears on entry to WAIT_LO and to WAIT_HI and increments each cycle spent in either state.
REQ-036 With MACRO_SCHED_WATCHDOG_EN defined, the counter reaching TIMEOUT_CYC without the awaited seq_st level -> RESP with done_valid=1 and done_err=1.
REQ-037 With MACRO_SCHED_WATCHDOG_EN undefined, no counter exists, WAIT states wait indefinitely, and done_err is tied to 0.

Verification
REQ-038 Reset, then req=01, width0=0, bank0=2, sequencer 12-bit -> gnt=01 and seq_start 1 cycle after req, seq_bank=2, seq_inwidth=0; done_valid with done_id=0 after seq_st returns high; job_cnt=1 after handshake.
REQ-039 req=11 held for 3 jobs with done_ready=1 -> grant order 0,1,0; done_id sequence 0,1,0.
REQ-040 done_ready=0 for 10 cycles in RESP -> done_valid, done_id and seq_bank stable, no gnt and busy=1; handshake -> IDLE and job_cnt increments once.
REQ-041 256 completed jobs -> job_cnt returns to 0.
REQ-042 With the watchdog enabled, TIMEOUT_CYC=8 and seq_st stuck at 1 -> done_valid=1, done_err=1 8 cycles after entering WAIT_LO; without the macro, busy stays 1.
REQ-043 rstn low in WAIT_HI -> all outputs at reset values the next cycle; a pending req=10 is granted to requester 1 normally afterwards.
